led_scan_ctrl: RTL and testbench
================================

// Module: led_scan_ctrl
// PURPOSE
// Bus-mapped scan scheduler for the 8-digit 7-segment display. Holds eight 8-bit
// ASCII digit codes written by the CPU over the peripheral register bus and
// time-multiplexes them: one digit per slot, with a brightness PWM and blink.
// Drives the segment decoder with the selected code and a one-hot digit select.
// Digit writes are double-buffered so the display does not tear mid-frame.
// PARAMETERS
// SLOT_CYC      50000  clocks per digit slot; must be a multiple of 16, >= 32
// BLINK_FRAMES  64     frames per blink half-period; >= 1
// PORTS
// Clk           in   1   system clock
// nRst          in   1   synchronous active-low reset
// req           in   1   bus request, one-cycle strobe
// we            in   1   1=write, 0=read; sampled with req
// addr          in   2   register index
// wdata         in   32  write data
// rdata         out  32  read data, valid while ack=1
// ack           out  1   one-cycle acknowledge
// digit_code    out  8   ASCII code of the currently selected digit, to decoder
// digit_sel     out  8   one-hot active-high digit enable; all-0 = blank
// frame_tick    out  1   one-cycle pulse at each frame boundary
// BEHAVIOUR
// - One clock (Clk); reset is synchronous and active-low (nRst), sampled on posedge Clk.
// - Register map (addr): 0 DIG_LO {d3,d2,d1,d0} bytes [31:0]; 1 DIG_HI {d7..d4};
//   2 CTRL [0]EN [1]BLINK [7:4]BRIGHT, other bits RAZ/WI; 3 STATUS (RO) [2:0]idx,
//   [3]pending, [15:8]frame_cnt. Writes to STATUS are ignored but acked.
// - Bus: a req in cycle N gives ack=1 in cycle N+1 only. rdata is 0 when ack=0.
//   Reads return the shadow digits (not the active digits). req while ack=1 is legal.
// - Shadow digits: a DIG write updates shadow and sets pending. At the frame boundary,
//   if pending=1: active<=shadow and pending<=0. A write in the boundary cycle copies
//   pre-write shadow; pending stays 1, so the new data lands one frame later.
// - Scan: slot_ctr counts 0..SLOT_CYC-1 and wraps. At wrap, idx advances 0..7 and
//   wraps 7->0. The frame boundary is the wrap with idx=7; frame_tick=1 in that cycle.
//   frame_cnt increments (mod 256) at each boundary.
// - Scan runs whenever nRst=1, independent of EN.
// - PWM: Q=SLOT_CYC/16. digit_sel[idx]=1 iff EN && slot_ctr < (BRIGHT+1)*Q and blink
//   is not in its off phase; otherwise digit_sel=0.
// - Blink: blink_ctr counts frames 0..BLINK_FRAMES-1. blink_ph toggles at wrap.
//   Off phase is BLINK=1 && blink_ph=1. Clearing BLINK shows the digits on the next cycle.
// - digit_code and digit_sel are registered: they reflect the idx/slot_ctr from the
//   previous cycle (1-cycle latency). digit_code=active[idx] even when blanked.
// - Reset values: slot_ctr=0, idx=0, shadow/active all 8'h20 (space), pending=0,
//   CTRL=0 (EN=0, BRIGHT=0), blink_ctr=0, blink_ph=0, frame_cnt=0, digit_sel=0,
//   digit_code=8'h20, ack=0, rdata=0, frame_tick=0.
// - Reset mid-frame or mid-transaction drops any in-flight ack. It does not complete
//   a pending copy.
// TESTING (SLOT_CYC=32, BLINK_FRAMES=2)
// 1 reset -> digit_sel=0, digit_code=8'h20, STATUS reads 0; write CTRL=8'hF1 ->
//   digit_sel walks 01,02,..,80,01 every 32 clocks, high the whole slot.
// 2 write DIG_LO=32'h34333231 at idx=2 -> digit_code unchanged until frame_tick;
//   next frame d0..d3 = 31,32,33,34; STATUS.pending 1 then 0.
// 3 CTRL=8'h71 (BRIGHT=7) -> digit_sel high 16 of 32 clocks per slot; BRIGHT=0 -> 2 clocks.
// 4 CTRL=8'hF3 -> 2 frames lit, 2 frames all-0, repeating; clear BLINK -> lit next cycle.
// 5 DIG write in the frame_tick cycle -> old shadow shown; new value after the next
//   boundary. A read in the following cycle returns the new value with ack.
// 6 nRst=0 mid-slot with pending=1 and req in flight -> no ack; all registers at reset
//   values; active stays 8'h20.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// Scan scheduler for an 8-digit 7-segment display: bus-mapped double-buffered digit
// registers, one-digit-per-slot multiplexing, brightness PWM and frame-based blink.
module led_scan_ctrl #(
    parameter int SLOT_CYC     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        Clk,
    input  logic        nRst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic [7:0]  digit_code,
    output logic [7:0]  digit_sel,
    output logic        frame_tick
);

    localparam int SW = $clog2(SLOT_CYC);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam int Q  = SLOT_CYC / 16;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [SW-1:0] slot_ctr;
    logic [2:0]    idx;
    logic [BW-1:0] blink_ctr;
    logic          blink_ph;
    logic [7:0]    frame_cnt;

    logic          en;
    logic          blink;
    logic [3:0]    bright;

    logic [7:0]    shadow [0:7];
    logic [7:0]    active [0:7];
    logic          pending;

    logic          slot_wrap;
    logic          boundary;
    logic          dig_wr;
    logic          ctrl_wr;
    logic [SW+4:0] pwm_lim;
    logic          lit;
    logic [31:0]   rd_mux;

    assign slot_wrap  = (slot_ctr == SLOT_LAST);
    assign boundary   = slot_wrap && (idx == 3'd7);
    assign frame_tick = boundary;
    assign dig_wr     = req && we && !addr[1];
    assign ctrl_wr    = req && we && (addr == 2'd2);

    // Lit window is (BRIGHT+1) sixteenths of the slot, suppressed during the blink off phase.
    always_comb begin
        pwm_lim = (SW+5)'({1'b0, bright} + 5'd1) * (SW+5)'(Q);
        lit     = en && ({5'd0, slot_ctr} < pwm_lim) && !(blink && blink_ph);
    end

    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            2'd0:    rd_mux = {shadow[3], shadow[2], shadow[1], shadow[0]};
            2'd1:    rd_mux = {shadow[7], shadow[6], shadow[5], shadow[4]};
            2'd2:    rd_mux = {24'd0, bright, 2'b00, blink, en};
            default: rd_mux = {16'd0, frame_cnt, 4'd0, pending, idx};
        endcase
    end

    // Scan timing runs regardless of EN so the frame rate never depends on software.
    always_ff @(posedge Clk) begin
        if (!nRst) begin
            slot_ctr  <= '0;
            idx       <= 3'd0;
            blink_ctr <= '0;
            blink_ph  <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            if (slot_wrap) begin
                slot_ctr <= '0;
                idx      <= idx + 3'd1;
            end else begin
                slot_ctr <= slot_ctr + SW'(1);
            end
            if (boundary) begin
                frame_cnt <= frame_cnt + 8'd1;
                if (blink_ctr == BLINK_LAST) begin
                    blink_ctr <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_ctr <= blink_ctr + BW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!nRst) begin
            en     <= 1'b0;
            blink  <= 1'b0;
            bright <= 4'd0;
            ack    <= 1'b0;
            rdata  <= 32'd0;
        end else begin
            ack   <= req;
            rdata <= (req && !we) ? rd_mux : 32'd0;
            if (ctrl_wr) begin
                en     <= wdata[0];
                blink  <= wdata[1];
                bright <= wdata[7:4];
            end
        end
    end

    // Copy uses pre-write shadow; a write in the boundary cycle keeps pending set for next frame.
    always_ff @(posedge Clk) begin
        if (!nRst) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 8'h20;
                active[i] <= 8'h20;
            end
            pending <= 1'b0;
        end else begin
            if (boundary && pending) begin
                for (int i = 0; i < 8; i++) begin
                    active[i] <= shadow[i];
                end
                pending <= 1'b0;
            end
            if (dig_wr) begin
                pending <= 1'b1;
                if (!addr[0]) begin
                    shadow[0] <= wdata[7:0];
                    shadow[1] <= wdata[15:8];
                    shadow[2] <= wdata[23:16];
                    shadow[3] <= wdata[31:24];
                end else begin
                    shadow[4] <= wdata[7:0];
                    shadow[5] <= wdata[15:8];
                    shadow[6] <= wdata[23:16];
                    shadow[7] <= wdata[31:24];
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!nRst) begin
            digit_code <= 8'h20;
            digit_sel  <= 8'd0;
        end else begin
            digit_code <= active[idx];
            digit_sel  <= lit ? (8'd1 << idx) : 8'd0;
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: bus responses go through a scoreboard queue checked
// by a monitor on ack; display outputs are checked at hand-computed cycle numbers.
module tb_led_scan_ctrl;

    logic        Clk;
    logic        nRst;
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic [7:0]  digit_code;
    logic [7:0]  digit_sel;
    logic        frame_tick;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    led_scan_ctrl #(.SLOT_CYC(32), .BLINK_FRAMES(2)) dut (
        .Clk        (Clk),
        .nRst       (nRst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ack        (ack),
        .digit_code (digit_code),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Cycle number since reset: in cycle c the scan sits at slot c%32, digit (c/32)%8.
    always @(posedge Clk) begin
        if (!nRst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (ack !== 1'b1 || rdata !== e.data) begin
                errors++;
                $display("[TB] FAIL bus_resp cyc=%0d: got ack=%b rdata=%h, want ack=1 rdata=%h",
                         cyc, ack, rdata, e.data);
            end
        end else begin
            checks++;
            if (ack !== 1'b0 || rdata !== 32'd0) begin
                errors++;
                $display("[TB] FAIL bus_idle cyc=%0d: got ack=%b rdata=%h, want ack=0 rdata=0",
                         cyc, ack, rdata);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d,
                                 input logic [31:0] exp);
        exp_t e;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        e.cyc  = cyc + 1;
        e.data = w ? 32'd0 : exp;
        exp_q.push_back(e);
        @(negedge Clk);
        req   = 1'b0;
        we    = 1'b0;
    endtask

    task automatic waitCyc(input int c);
        int guard = 0;
        while (cyc != c) begin
            @(negedge Clk);
            guard++;
            if (guard > 4000) begin
                errors++;
                $display("[TB] FAIL wait_cyc: got cyc=%0d, want %0d", cyc, c);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "[TB] timeout");
            end
        end
    endtask

    initial begin
        nRst  = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        repeat (3) @(negedge Clk);
        checkOutput("rst_sel",  {24'd0, digit_sel},  32'h00);
        checkOutput("rst_code", {24'd0, digit_code}, 32'h20);
        nRst = 1'b1;

        $display("[TB] reset state, scan walk at full brightness");
        waitCyc(2); applyStimulus(1'b0, 2'd3, 32'd0, 32'h0000_0000);
        waitCyc(4); applyStimulus(1'b1, 2'd2, 32'hABCD_12FD, 32'd0);
        waitCyc(6); applyStimulus(1'b0, 2'd2, 32'd0, 32'h0000_00F1);
        waitCyc(10);
        checkOutput("walk_d0", {24'd0, digit_sel}, 32'h01);
        for (int k = 1; k <= 8; k++) begin
            waitCyc(32 * k);
            checkOutput("walk_slot_end", {24'd0, digit_sel}, 32'd1 << ((k - 1) % 8));
            waitCyc(32 * k + 1);
            checkOutput("walk_slot_start", {24'd0, digit_sel}, 32'd1 << (k % 8));
            waitCyc(32 * k + 10);
            checkOutput("walk_mid", {24'd0, digit_sel}, 32'd1 << (k % 8));
        end

        $display("[TB] double-buffered digit write");
        waitCyc(325); applyStimulus(1'b1, 2'd0, 32'h3433_3231, 32'd0);
        waitCyc(330); applyStimulus(1'b0, 2'd3, 32'd0, 32'h0000_010A);
        waitCyc(335); applyStimulus(1'b0, 2'd0, 32'd0, 32'h3433_3231);
        waitCyc(357); checkOutput("code_before_tick", {24'd0, digit_code}, 32'h20);
        waitCyc(510); checkOutput("tick_low",  {31'd0, frame_tick}, 32'd0);
        waitCyc(511); checkOutput("tick_high", {31'd0, frame_tick}, 32'd1);
        waitCyc(512); checkOutput("code_d7_old", {24'd0, digit_code}, 32'h20);
        waitCyc(513); checkOutput("code_d0_new", {24'd0, digit_code}, 32'h31);
        waitCyc(515); applyStimulus(1'b0, 2'd3, 32'd0, 32'h0000_0200);
        waitCyc(552); checkOutput("code_d1", {24'd0, digit_code}, 32'h32);
        waitCyc(584); checkOutput("code_d2", {24'd0, digit_code}, 32'h33);
        waitCyc(616); checkOutput("code_d3", {24'd0, digit_code}, 32'h34);
        waitCyc(648); checkOutput("code_d4", {24'd0, digit_code}, 32'h20);

        $display("[TB] brightness PWM");
        waitCyc(700); applyStimulus(1'b1, 2'd2, 32'h0000_0071, 32'd0);
        waitCyc(704); checkOutput("b7_prev_end",  {24'd0, digit_sel}, 32'h00);
        waitCyc(705); checkOutput("b7_first",     {24'd0, digit_sel}, 32'h40);
        waitCyc(720); checkOutput("b7_last_lit",  {24'd0, digit_sel}, 32'h40);
        waitCyc(721); checkOutput("b7_first_off", {24'd0, digit_sel}, 32'h00);
        waitCyc(740); applyStimulus(1'b1, 2'd2, 32'h0000_0001, 32'd0);
        waitCyc(768); checkOutput("b0_prev_end",  {24'd0, digit_sel}, 32'h00);
        waitCyc(769); checkOutput("b0_first",     {24'd0, digit_sel}, 32'h01);
        waitCyc(770); checkOutput("b0_second",    {24'd0, digit_sel}, 32'h01);
        waitCyc(771); checkOutput("b0_third_off", {24'd0, digit_sel}, 32'h00);

        $display("[TB] blink");
        waitCyc(800);  applyStimulus(1'b1, 2'd2, 32'h0000_00F3, 32'd0);
        waitCyc(900);  checkOutput("blink_off_a",   {24'd0, digit_sel}, 32'h00);
        waitCyc(1024); checkOutput("blink_off_end", {24'd0, digit_sel}, 32'h00);
        waitCyc(1025); checkOutput("blink_on_start", {24'd0, digit_sel}, 32'h01);
        waitCyc(1300); checkOutput("blink_on_mid",  {24'd0, digit_sel}, 32'h01);
        waitCyc(1535); checkOutput("blink_on_late", {24'd0, digit_sel}, 32'h80);
        waitCyc(1536); checkOutput("blink_on_end",  {24'd0, digit_sel}, 32'h80);
        waitCyc(1537); checkOutput("blink_off_b",   {24'd0, digit_sel}, 32'h00);
        waitCyc(1600); checkOutput("blink_off_sel", {24'd0, digit_sel}, 32'h00);
        checkOutput("blink_off_code", {24'd0, digit_code}, 32'h32);
        waitCyc(1700); applyStimulus(1'b1, 2'd2, 32'h0000_00F1, 32'd0);
        waitCyc(1701); checkOutput("unblink_old", {24'd0, digit_sel}, 32'h00);
        waitCyc(1702); checkOutput("unblink_new", {24'd0, digit_sel}, 32'h20);

        $display("[TB] write in the frame boundary cycle");
        waitCyc(1750); applyStimulus(1'b1, 2'd1, 32'h4443_4241, 32'd0);
        waitCyc(1791);
        checkOutput("tick_b7", {31'd0, frame_tick}, 32'd1);
        applyStimulus(1'b1, 2'd1, 32'h3837_3635, 32'd0);
        applyStimulus(1'b0, 2'd1, 32'd0, 32'h3837_3635);
        waitCyc(1794); applyStimulus(1'b0, 2'd3, 32'd0, 32'h0000_0708);
        waitCyc(1925);
        checkOutput("old_shadow_code", {24'd0, digit_code}, 32'h41);
        checkOutput("old_shadow_sel",  {24'd0, digit_sel},  32'h10);
        waitCyc(2100); applyStimulus(1'b0, 2'd3, 32'd0, 32'h0000_0801);
        waitCyc(2181); checkOutput("new_code_d4", {24'd0, digit_code}, 32'h35);
        waitCyc(2277); checkOutput("new_code_d7", {24'd0, digit_code}, 32'h38);

        $display("[TB] reset with pending copy and request in flight");
        waitCyc(2300); applyStimulus(1'b1, 2'd0, 32'h5A5A_5A5A, 32'd0);
        waitCyc(2310);
        req  = 1'b1;
        we   = 1'b0;
        addr = 2'd3;
        nRst = 1'b0;
        @(negedge Clk);
        req = 1'b0;
        checkOutput("rst_ack",  {31'd0, ack},        32'd0);
        checkOutput("rst_sel2", {24'd0, digit_sel},  32'h00);
        checkOutput("rst_code2", {24'd0, digit_code}, 32'h20);
        checkOutput("rst_tick", {31'd0, frame_tick}, 32'd0);
        @(negedge Clk);
        nRst = 1'b1;
        waitCyc(2);   applyStimulus(1'b0, 2'd3, 32'd0, 32'h0000_0000);
        waitCyc(4);   applyStimulus(1'b0, 2'd0, 32'd0, 32'h2020_2020);
        waitCyc(6);   applyStimulus(1'b0, 2'd2, 32'd0, 32'h0000_0000);
        waitCyc(8);   applyStimulus(1'b0, 2'd1, 32'd0, 32'h2020_2020);
        waitCyc(20);
        checkOutput("post_rst_code", {24'd0, digit_code}, 32'h20);
        checkOutput("post_rst_sel",  {24'd0, digit_sel},  32'h00);
        waitCyc(300); checkOutput("post_rst_frame_code", {24'd0, digit_code}, 32'h20);
        waitCyc(301); applyStimulus(1'b0, 2'd3, 32'd0, 32'h0000_0101);

        repeat (3) @(negedge Clk);
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL bus_missing: got no response for cyc=%0d, want rdata=%h", e.cyc, e.data);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
